// File: rtl/contador_timer_ctrl.sv
// contador_timer_ctrl
// Sequencing controller that wraps a free-running up counter into a
// configurable timer: prescaler, terminal count, one-shot or periodic
// reload, and start/stop/pause control. Configuration arrives through a
// valid/ready handshake. Status and events leave as registered signals.
module contador_timer_ctrl #(
    parameter int WIDTH      = 6,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_presc,
    input  logic                  cfg_periodic,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [WIDTH-1:0]      count_q,     count_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]      limit_q,     limit_d;
    logic [PRESCALE_W-1:0] presc_q,     presc_d;
    logic                  periodic_q,  periodic_d;
    logic                  tick_q,      tick_d;
    logic                  done_q;
    logic                  busy_q;
    logic                  cfg_ready_q;
    logic                  cfg_fire;
    logic                  presc_wrap;

    // A step is terminal once the count has reached the limit; using >=
    // guarantees the counter can never run past the limit.
    function automatic logic is_terminal(input logic [WIDTH-1:0] cnt,
                                         input logic [WIDTH-1:0] lim);
        return (cnt >= lim);
    endfunction

    // Prescaler advances until it matches the programmed divisor-minus-one.
    function automatic logic [PRESCALE_W-1:0] presc_next(input logic [PRESCALE_W-1:0] cnt);
        return cnt + 1'b1;
    endfunction

    // The handshake completes on the registered ready, so a config offered
    // while the timer is busy simply waits until ready rises again.
    assign cfg_fire   = cfg_valid && cfg_ready_q;
    assign presc_wrap = (presc_cnt_q == presc_q);

    // Next-state logic; priority is stop, config, start, pause, step.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        limit_d     = limit_q;
        presc_d     = presc_q;
        periodic_d  = periodic_q;
        tick_d      = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            count_d     = '0;
            presc_cnt_d = '0;
        end else if (cfg_fire) begin
            limit_d     = cfg_limit;
            presc_d     = cfg_presc;
            periodic_d  = cfg_periodic;
            count_d     = '0;
            presc_cnt_d = '0;
            state_d     = IDLE;
        end else if (start && (state_q == IDLE || state_q == DONE)) begin
            state_d     = RUN;
            count_d     = '0;
            presc_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (presc_wrap) begin
                        presc_cnt_d = '0;
                        if (is_terminal(count_q, limit_q)) begin
                            tick_d = 1'b1;
                            if (periodic_q) begin
                                count_d = '0;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        presc_cnt_d = presc_next(presc_cnt_q);
                    end
                end
                PAUSE: begin
                    // Count and prescaler stay frozen; releasing pause only
                    // returns to RUN so the prescale phase resumes where it was.
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            presc_cnt_q <= '0;
            limit_q     <= '1;
            presc_q     <= '0;
            periodic_q  <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            limit_q     <= limit_d;
            presc_q     <= presc_d;
            periodic_q  <= periodic_d;
            tick_q      <= tick_d;
            done_q      <= (state_d == DONE);
            busy_q      <= (state_d == RUN) || (state_d == PAUSE);
            cfg_ready_q <= (state_d == IDLE) || (state_d == DONE);
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_contador_timer_ctrl.sv
// Scoreboard bench for contador_timer_ctrl: the stimulus process queues
// expected status snapshots (keyed by cycle) and expected tick cycles;
// a monitor on the falling edge pops and compares them.
module tb_contador_timer_ctrl;

    localparam int W  = 6;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_limit = '0;
    logic [PW-1:0] cfg_presc = '0;
    logic          cfg_periodic = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [W-1:0]  count;
    logic          tick;
    logic          done;
    logic          busy;

    contador_timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_presc    (cfg_presc),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .count        (count),
        .tick         (tick),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [9:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   tick_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_end = 1'b0;
    logic [9:0] act;

    task automatic exp_st(input int c, input int cnt, input bit tk, input bit dn,
                          input bit bz, input bit rd);
        exp_t e;
        e.c = c;
        e.v = {cnt[W-1:0], tk, dn, bz, rd};
        exp_q.push_back(e);
    endtask

    task automatic exp_tick(input int c);
        tick_q.push_back(c);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compares queued expectations against the DUT away from the active edge.
    always @(negedge clk) begin
        act = {count, tick, done, busy, cfg_ready};
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL status_missed cyc=%0d got none required %h", exp_q[0].c, exp_q[0].v);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            checks++;
            if (act !== exp_q[0].v) begin
                errors++;
                $display("FAIL status@%0d got cnt=%0d tick=%b done=%b busy=%b rdy=%b required cnt=%0d tick=%b done=%b busy=%b rdy=%b",
                         cyc, act[9:4], act[3], act[2], act[1], act[0],
                         exp_q[0].v[9:4], exp_q[0].v[3], exp_q[0].v[2], exp_q[0].v[1], exp_q[0].v[0]);
            end
            void'(exp_q.pop_front());
        end
        while (tick_q.size() > 0 && tick_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL tick_missing got 0 required tick at cyc %0d", tick_q[0]);
            void'(tick_q.pop_front());
        end
        if (tick === 1'b1) begin
            checks++;
            if (tick_q.size() > 0 && tick_q[0] == cyc) begin
                void'(tick_q.pop_front());
            end else begin
                errors++;
                $display("FAIL tick_unexpected got tick=1 at cyc %0d required 0", cyc);
            end
        end
        if (stim_end) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL status_leftover got %0d pending required 0", exp_q.size());
            end
            checks++;
            if (tick_q.size() != 0) begin
                errors++;
                $display("FAIL tick_leftover got %0d pending required 0", tick_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int b;
        int e0;

        // Reset state
        repeat (2) @(negedge clk);
        exp_st(cyc + 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: default config, one-shot to 63
        @(negedge clk);
        start = 1'b1;
        b = cyc;
        exp_st(b + 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        start = 1'b0;
        e0 = b + 1;
        for (int k = 1; k <= 63; k++) exp_st(e0 + k, k, 0, 0, 1, 0);
        exp_st(e0 + 64, 63, 1, 1, 0, 1);
        exp_tick(e0 + 64);
        exp_st(e0 + 65, 63, 0, 1, 0, 1);
        wait_until(e0 + 65);

        // 2: limit=5 presc=2 periodic
        cfg_valid = 1'b1; cfg_limit = 6'd5; cfg_presc = 4'd2; cfg_periodic = 1'b1;
        b = cyc;
        exp_st(b + 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b1;
        exp_st(b + 2, 0, 0, 0, 1, 0);
        @(negedge clk);
        start = 1'b0;
        e0 = b + 2;
        exp_st(e0 + 2, 0, 0, 0, 1, 0);
        exp_st(e0 + 3, 1, 0, 0, 1, 0);
        exp_st(e0 + 6, 2, 0, 0, 1, 0);
        exp_st(e0 + 15, 5, 0, 0, 1, 0);
        exp_st(e0 + 17, 5, 0, 0, 1, 0);
        exp_st(e0 + 18, 0, 1, 0, 1, 0);
        exp_st(e0 + 19, 0, 0, 0, 1, 0);
        exp_st(e0 + 21, 1, 0, 0, 1, 0);
        exp_st(e0 + 36, 0, 1, 0, 1, 0);
        exp_tick(e0 + 18);
        exp_tick(e0 + 36);
        wait_until(e0 + 37);
        stop = 1'b1;
        exp_st(e0 + 38, 0, 0, 0, 0, 1);
        @(negedge clk);

        // 3: limit=0 presc=0 periodic, tick every cycle
        stop = 1'b0;
        cfg_valid = 1'b1; cfg_limit = 6'd0; cfg_presc = 4'd0; cfg_periodic = 1'b1;
        b = cyc;
        exp_st(b + 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = b + 2;
        for (int d = 1; d <= 8; d++) exp_tick(e0 + d);
        exp_st(e0 + 1, 0, 1, 0, 1, 0);
        exp_st(e0 + 8, 0, 1, 0, 1, 0);
        wait_until(e0 + 8);
        stop = 1'b1;
        exp_st(e0 + 9, 0, 0, 0, 0, 1);
        @(negedge clk);
        stop = 1'b0;

        // 4 and 5: pause at count 3, then stop+pause at count 10, held-off config
        cfg_valid = 1'b1; cfg_limit = 6'd10; cfg_presc = 4'd1; cfg_periodic = 1'b1;
        b = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = b + 2;
        exp_st(e0 + 6, 3, 0, 0, 1, 0);
        exp_st(e0 + 8, 3, 0, 0, 1, 0);
        exp_st(e0 + 11, 3, 0, 0, 1, 0);
        exp_st(e0 + 12, 3, 0, 0, 1, 0);
        exp_st(e0 + 13, 4, 0, 0, 1, 0);
        exp_st(e0 + 15, 5, 0, 0, 1, 0);
        exp_st(e0 + 21, 8, 0, 0, 1, 0);
        exp_st(e0 + 25, 10, 0, 0, 1, 0);
        exp_st(e0 + 27, 0, 0, 0, 0, 1);
        exp_st(e0 + 28, 0, 0, 0, 0, 1);
        exp_st(e0 + 29, 0, 0, 0, 1, 0);
        exp_st(e0 + 31, 2, 0, 0, 1, 0);
        exp_st(e0 + 32, 2, 1, 1, 0, 1);
        exp_tick(e0 + 32);
        wait_until(e0 + 7);
        pause = 1'b1;
        wait_until(e0 + 11);
        pause = 1'b0;
        wait_until(e0 + 20);
        cfg_valid = 1'b1; cfg_limit = 6'd2; cfg_presc = 4'd0; cfg_periodic = 1'b0;
        wait_until(e0 + 26);
        stop = 1'b1;
        pause = 1'b1;
        wait_until(e0 + 27);
        stop = 1'b0;
        pause = 1'b0;
        wait_until(e0 + 28);
        cfg_valid = 1'b0;
        start = 1'b1;
        wait_until(e0 + 29);
        start = 1'b0;
        wait_until(e0 + 33);

        // 6: asynchronous reset mid-count, defaults restored
        cfg_valid = 1'b1; cfg_limit = 6'd30; cfg_presc = 4'd0; cfg_periodic = 1'b1;
        b = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = b + 2;
        exp_st(e0 + 20, 20, 0, 0, 1, 0);
        exp_st(e0 + 21, 0, 0, 0, 0, 1);
        exp_st(e0 + 22, 0, 0, 0, 0, 1);
        wait_until(e0 + 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        b = cyc;
        e0 = b + 1;
        exp_st(e0 + 63, 63, 0, 0, 1, 0);
        exp_st(e0 + 64, 63, 1, 1, 0, 1);
        exp_tick(e0 + 64);
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 66);
        stim_end = 1'b1;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
